row_scanner: RTL and testbench

//  Scan-out end of the row-buffer interface. Reads one 480-px row of 24-bit RGB from the

---
 rtl/squares_vga_pkg.sv | 55 +++++
 rtl/vga_timing.sv | 82 ++++++++
 rtl/row_scanner.sv | 173 +++++++++++++++++
 tb/tb_row_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/squares_vga_pkg.sv
// Shared timing constants and types for the row-buffer VGA scan-out path.
//
// Contents:
//   H_/V_ timing localparams (640x480@60), H_TOTAL, V_TOTAL, ROW_WIDTH
//   pixel_t      24-bit {R,G,B} pixel, 0 = transparent/black
//   row_addr_t   9-bit row-buffer address
//   count_t      10-bit h/v counter
//   scan_state_e per-axis scan phase (active, front porch, sync, back porch)
//   scan_state() maps a counter value onto its scan phase
package squares_vga_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned ROW_WIDTH = 480;

  typedef logic [23:0] pixel_t;
  typedef logic [8:0]  row_addr_t;
  typedef logic [9:0]  count_t;

  typedef enum logic [1:0] {
    StActive,
    StFp,
    StSync,
    StBp
  } scan_state_e;

  // Boundaries are exclusive end points of each phase along one axis.
  function automatic scan_state_e scan_state(input count_t cnt,
                                             input count_t active_end,
                                             input count_t fp_end,
                                             input count_t sync_end);
    scan_state_e st;
    if (cnt < active_end) begin
      st = StActive;
    end else if (cnt < fp_end) begin
      st = StFp;
    end else if (cnt < sync_end) begin
      st = StSync;
    end else begin
      st = StBp;
    end
    return st;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: horizontal/vertical counters with per-axis scan-phase FSMs.
//
// Ports:
//   clk_i          pixel clock
//   reset_i        synchronous, active-high; h=0, v=last line
//   h_next_o       next-cycle horizontal count (lets callers register stage-0 values)
//   v_next_o       next-cycle vertical count
//   hs_o, vs_o     sync, active low, aligned with the current counts
//   active_o       current pixel lies in the visible field
//   frame_start_o  1-clk strobe while the counts sit at h=0, v=0
module vga_timing import squares_vga_pkg::*; #(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFp     = H_FP,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBp     = H_BP,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFp     = V_FP,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBp     = V_BP
) (
  input  logic   clk_i,
  input  logic   reset_i,
  output count_t h_next_o,
  output count_t v_next_o,
  output logic   hs_o,
  output logic   vs_o,
  output logic   active_o,
  output logic   frame_start_o
);

  localparam count_t HActEnd  = count_t'(HActive);
  localparam count_t HFpEnd   = count_t'(HActive + HFp);
  localparam count_t HSyncEnd = count_t'(HActive + HFp + HSync);
  localparam count_t HLast    = count_t'(HActive + HFp + HSync + HBp - 1);

  localparam count_t VActEnd  = count_t'(VActive);
  localparam count_t VFpEnd   = count_t'(VActive + VFp);
  localparam count_t VSyncEnd = count_t'(VActive + VFp + VSync);
  localparam count_t VLast    = count_t'(VActive + VFp + VSync + VBp - 1);

  count_t      h_q, h_d;
  count_t      v_q, v_d;
  scan_state_e h_state_q, h_state_d;
  scan_state_e v_state_q, v_state_d;
  logic        frame_start_q;

  always_comb begin
    h_d = (h_q == HLast) ? '0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
    h_state_d = scan_state(h_d, HActEnd, HFpEnd, HSyncEnd);
    v_state_d = scan_state(v_d, VActEnd, VFpEnd, VSyncEnd);
  end

  // States are kept in step with the counters so the decoded outputs below
  // come straight from flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q           <= '0;
      v_q           <= VLast;
      h_state_q     <= scan_state('0, HActEnd, HFpEnd, HSyncEnd);
      v_state_q     <= scan_state(VLast, VActEnd, VFpEnd, VSyncEnd);
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      frame_start_q <= (h_d == '0) && (v_d == '0);
    end
  end

  assign h_next_o      = h_d;
  assign v_next_o      = v_d;
  assign hs_o          = (h_state_q != StSync);
  assign vs_o          = (v_state_q != StSync);
  assign active_o      = (h_state_q == StActive) && (v_state_q == StActive);
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/row_scanner.sv
// Scan-out end of the double-buffered row RAM. Reads one row per visible line
// from the front half, drives VGA colour/sync, and pulses swap once per line so
// the drawer refills the back half with the following row.
//
// Pipeline: stage0 = counters + read address, stage1 = RAM data,
// stage2 = registered colour/sync outputs (sync, blank, frame_start delayed 2 clk).
//
// Build option ROW_CLEAR_EN: when defined, each read location is zeroed one clk
// after it is read (wren_clear/address_clear). Otherwise both stay at 0.
//
// Ports:
//   clk, reset           pixel clock, synchronous active-high reset
//   address_read_row     front-buffer read address (held outside the row window)
//   data_read_row        RAM read data {R,G,B}, valid 1 clk after the address
//   buf_sel              front-buffer index; drawer writes go to ~buf_sel
//   swap                 1-clk pulse when the buffers exchange
//   address_clear        front-buffer clear address
//   wren_clear           front-buffer clear write enable (data 0)
//   vga_r/vga_g/vga_b    colour, 0 outside the displayed row
//   vga_hs, vga_vs       sync, active low
//   vga_blank_n          1 during active video
//   frame_start          1-clk pulse with the first active pixel of line 0
module row_scanner import squares_vga_pkg::*; #(
  parameter int unsigned HActive  = H_ACTIVE,
  parameter int unsigned HFp      = H_FP,
  parameter int unsigned HSync    = H_SYNC,
  parameter int unsigned HBp      = H_BP,
  parameter int unsigned VActive  = V_ACTIVE,
  parameter int unsigned VFp      = V_FP,
  parameter int unsigned VSync    = V_SYNC,
  parameter int unsigned VBp      = V_BP,
  parameter int unsigned RowWidth = ROW_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic [8:0]  address_read_row,
  input  logic [23:0] data_read_row,
  output logic        buf_sel,
  output logic        swap,
  output logic [8:0]  address_clear,
  output logic        wren_clear,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam count_t HActEnd     = count_t'(HActive);
  localparam count_t RowEnd      = count_t'(RowWidth);
  localparam count_t VActEnd     = count_t'(VActive);
  localparam count_t VLastActive = count_t'(VActive - 1);
  localparam count_t VLast       = count_t'(VActive + VFp + VSync + VBp - 1);

  count_t h_next, v_next;
  logic   hs_s0, vs_s0, active_s0, frame_start_s0;

  vga_timing #(
    .HActive (HActive),
    .HFp     (HFp),
    .HSync   (HSync),
    .HBp     (HBp),
    .VActive (VActive),
    .VFp     (VFp),
    .VSync   (VSync),
    .VBp     (VBp)
  ) u_vga_timing (
    .clk_i         (clk),
    .reset_i       (reset),
    .h_next_o      (h_next),
    .v_next_o      (v_next),
    .hs_o          (hs_s0),
    .vs_o          (vs_s0),
    .active_o      (active_s0),
    .frame_start_o (frame_start_s0)
  );

  // Stage-0 decisions are made on next-cycle counts so the registered address
  // and swap line up with the counters they belong to.
  logic rd_d, swap_d;

  always_comb begin
    rd_d   = (h_next < RowEnd) && (v_next < VActEnd);
    // Swap on the last visible line's successor is skipped: the row shown at
    // line V_ACTIVE-1 is the last one, and the swap on the final blank line
    // brings row 0 forward for the next frame.
    swap_d = (h_next == HActEnd) && ((v_next < VLastActive) || (v_next == VLast));
  end

  logic      rd_q, rd_s1_q;
  row_addr_t addr_q;
  logic      swap_q, buf_sel_q;
  pixel_t    rgb_q;
  logic      hs_s1_q, hs_s2_q;
  logic      vs_s1_q, vs_s2_q;
  logic      blank_n_s1_q, blank_n_s2_q;
  logic      fs_s1_q, fs_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q         <= 1'b0;
      rd_s1_q      <= 1'b0;
      addr_q       <= '0;
      swap_q       <= 1'b0;
      buf_sel_q    <= 1'b0;
      rgb_q        <= '0;
      hs_s1_q      <= 1'b1;
      hs_s2_q      <= 1'b1;
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      blank_n_s1_q <= 1'b0;
      blank_n_s2_q <= 1'b0;
      fs_s1_q      <= 1'b0;
      fs_s2_q      <= 1'b0;
    end else begin
      // Stage 0
      rd_q <= rd_d;
      if (rd_d) begin
        addr_q <= h_next[8:0];
      end
      swap_q    <= swap_d;
      buf_sel_q <= buf_sel_q ^ swap_d;
      // Stage 1: RAM data for addr_q arrives this cycle
      rd_s1_q      <= rd_q;
      hs_s1_q      <= hs_s0;
      vs_s1_q      <= vs_s0;
      blank_n_s1_q <= active_s0;
      fs_s1_q      <= frame_start_s0;
      // Stage 2
      rgb_q        <= rd_s1_q ? data_read_row : '0;
      hs_s2_q      <= hs_s1_q;
      vs_s2_q      <= vs_s1_q;
      blank_n_s2_q <= blank_n_s1_q;
      fs_s2_q      <= fs_s1_q;
    end
  end

`ifdef ROW_CLEAR_EN
  logic      wren_clear_q;
  row_addr_t addr_clear_q;

  // Zero each location the cycle after it is read, while it is still front.
  always_ff @(posedge clk) begin
    if (reset) begin
      wren_clear_q <= 1'b0;
      addr_clear_q <= '0;
    end else begin
      wren_clear_q <= rd_q;
      addr_clear_q <= addr_q;
    end
  end

  assign wren_clear    = wren_clear_q;
  assign address_clear = addr_clear_q;
`else
  assign wren_clear    = 1'b0;
  assign address_clear = '0;
`endif

  assign address_read_row = addr_q;
  assign swap             = swap_q;
  assign buf_sel          = buf_sel_q;
  assign vga_r            = rgb_q[23:16];
  assign vga_g            = rgb_q[15:8];
  assign vga_b            = rgb_q[7:0];
  assign vga_hs           = hs_s2_q;
  assign vga_vs           = vs_s2_q;
  assign vga_blank_n      = blank_n_s2_q;
  assign frame_start      = fs_s2_q;

endmodule

// File: tb/tb_row_scanner.sv
// Self-checking bench for row_scanner on a reduced raster (same structure as
// 640x480, scaled down so whole frames fit in a short run).
module tb_row_scanner;

  localparam int HA = 40;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int RW = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  address_read_row;
  logic [23:0] data_read_row;
  logic        buf_sel, swap, wren_clear;
  logic [8:0]  address_clear;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  always #5 clk = ~clk;

  row_scanner #(
    .HActive  (HA),
    .HFp      (HF),
    .HSync    (HS),
    .HBp      (HB),
    .VActive  (VA),
    .VFp      (VF),
    .VSync    (VS),
    .VBp      (VB),
    .RowWidth (RW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .address_read_row (address_read_row),
    .data_read_row    (data_read_row),
    .buf_sel          (buf_sel),
    .swap             (swap),
    .address_clear    (address_clear),
    .wren_clear       (wren_clear),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hs           (vga_hs),
    .vga_vs           (vga_vs),
    .vga_blank_n      (vga_blank_n),
    .frame_start      (frame_start)
  );

  // RAM model, 1-clk latency; front row content = tagged column index.
  always @(posedge clk) data_read_row <= {8'h40, 7'd0, address_read_row};

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        fs;
  } out_t;

  out_t exp_q[$];
  int   swap_cyc[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   h_m, v_m, cyc;
  logic [8:0] addr_m, addr_prev;
  logic buf_m, rd_prev;
  int   cnt_swap, cnt_vs_low, cnt_fs, cnt_blank, cnt_wren;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d h %0d v %0d)", tag, got, exp, cyc, h_m,
               v_m);
    end
  endtask

  function automatic out_t reset_out();
    out_t o;
    o.rgb = '0; o.hs = 1'b1; o.vs = 1'b1; o.blank_n = 1'b0; o.fs = 1'b0;
    return o;
  endfunction

  task automatic model_reset();
    h_m = 0; v_m = VT - 1; cyc = 0;
    addr_m = '0; addr_prev = '0; buf_m = 1'b0; rd_prev = 1'b0;
    exp_q.delete();
    exp_q.push_back(reset_out());
    exp_q.push_back(reset_out());
  endtask

  task automatic clear_stats();
    cnt_swap = 0; cnt_vs_low = 0; cnt_fs = 0; cnt_blank = 0; cnt_wren = 0;
    swap_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_addr"},     32'(address_read_row), 32'd0);
    check_eq({pfx, "_buf_sel"},  32'(buf_sel), 32'd0);
    check_eq({pfx, "_swap"},     32'(swap), 32'd0);
    check_eq({pfx, "_wren"},     32'(wren_clear), 32'd0);
    check_eq({pfx, "_addr_clr"}, 32'(address_clear), 32'd0);
    check_eq({pfx, "_rgb"},      32'({vga_r, vga_g, vga_b}), 32'd0);
    check_eq({pfx, "_hs"},       32'(vga_hs), 32'd1);
    check_eq({pfx, "_vs"},       32'(vga_vs), 32'd1);
    check_eq({pfx, "_blank_n"},  32'(vga_blank_n), 32'd0);
    check_eq({pfx, "_fs"},       32'(frame_start), 32'd0);
  endtask

  // Called at a negedge: checks this cycle, advances the model, waits one clk.
  task automatic run_cycles(input int n);
    logic rd, sw;
    out_t e, nx;
    for (int i = 0; i < n; i++) begin
      rd = (h_m < RW) && (v_m < VA);
      if (rd) addr_m = 9'(h_m);
      check_eq("addr", 32'(address_read_row), 32'(addr_m));
      sw = (h_m == HA) && ((v_m < VA - 1) || (v_m == VT - 1));
      if (sw) buf_m = ~buf_m;
      check_eq("swap", 32'(swap), 32'(sw));
      check_eq("buf_sel", 32'(buf_sel), 32'(buf_m));
`ifdef ROW_CLEAR_EN
      check_eq("wren_clear", 32'(wren_clear), 32'(rd_prev));
      if (rd_prev) check_eq("addr_clear", 32'(address_clear), 32'(addr_prev));
`else
      check_eq("wren_clear", 32'(wren_clear), 32'd0);
      check_eq("addr_clear", 32'(address_clear), 32'd0);
`endif
      rd_prev = rd;
      addr_prev = addr_m;

      e = exp_q.pop_front();
      check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      check_eq("hs", 32'(vga_hs), 32'(e.hs));
      check_eq("vs", 32'(vga_vs), 32'(e.vs));
      check_eq("blank_n", 32'(vga_blank_n), 32'(e.blank_n));
      check_eq("frame_start", 32'(frame_start), 32'(e.fs));

      nx.rgb     = rd ? {8'h40, 7'd0, 9'(h_m)} : 24'h0;
      nx.hs      = !((h_m >= HA + HF) && (h_m < HA + HF + HS));
      nx.vs      = !((v_m >= VA + VF) && (v_m < VA + VF + VS));
      nx.blank_n = (h_m < HA) && (v_m < VA);
      nx.fs      = (h_m == 0) && (v_m == 0);
      exp_q.push_back(nx);

      if (swap === 1'b1) begin
        cnt_swap++;
        swap_cyc.push_back(cyc);
      end
      if (vga_vs === 1'b0) cnt_vs_low++;
      if (frame_start === 1'b1) cnt_fs++;
      if (vga_blank_n === 1'b1) cnt_blank++;
      if (wren_clear === 1'b1) cnt_wren++;

      if (h_m == HT - 1) begin
        h_m = 0;
        v_m = (v_m == VT - 1) ? 0 : v_m + 1;
      end else begin
        h_m++;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string pfx);
    check_eq({pfx, "_swaps"}, 32'(cnt_swap), 32'(VA));
    check_eq({pfx, "_vs_low_clk"}, 32'(cnt_vs_low), 32'(VS * HT));
    check_eq({pfx, "_frame_start"}, 32'(cnt_fs), 32'd1);
    check_eq({pfx, "_blank_n_clk"}, 32'(cnt_blank), 32'(VA * HA));
`ifdef ROW_CLEAR_EN
    check_eq({pfx, "_clears"}, 32'(cnt_wren), 32'(VA * RW));
`else
    check_eq({pfx, "_clears"}, 32'(cnt_wren), 32'd0);
`endif
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    model_reset();

    // Frame 1 from release: first line is the final blank line.
    clear_stats();
    run_cycles(HT * VT);
    check_eq("swap_seen_twice", 32'(swap_cyc.size() >= 2), 32'd1);
    if (swap_cyc.size() >= 2) begin
      check_eq("first_swap_clk", 32'(swap_cyc[0]), 32'(HA));
      check_eq("second_swap_clk", 32'(swap_cyc[1]), 32'(HA + HT));
    end
    check_frame("frame1");

    clear_stats();
    run_cycles(HT * VT);
    check_frame("frame2");

    // Mid-frame reset at v=7, h=25.
    guard = 0;
    while (!(v_m == 7 && h_m == 25) && guard < HT * VT) begin
      run_cycles(1);
      guard++;
    end
    check_eq("seek_mid_frame", 32'(v_m == 7 && h_m == 25), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    model_reset();
    clear_stats();
    run_cycles(HA + 4);
    check_eq("midrst_swap_seen", 32'(swap_cyc.size() >= 1), 32'd1);
    if (swap_cyc.size() >= 1) check_eq("midrst_swap_clk", 32'(swap_cyc[0]), 32'(HA));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
